machine_timer: RTL

- Memory-mapped machine timer; the interrupt source that drives the timer bit of the core's interrupt request vector (`int_flag_i` of the interrupt arbiter).
- 64-bit free-running mtime with a 16-bit prescaler and a 64-bit mtimecmp compare.
- Sticky pending flag, software-acknowledged (W1C or mtimecmp rewrite).
- Sits on the peripheral bus; int_sig_o maps to `INT_TIMER0` at top level.

---
 rtl/machine_timer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit prescaled mtime, 64-bit mtimecmp, sticky pending IRQ.
// Optional MTIMER_AUTO_RELOAD_EN: CTRL[3] reload restarts mtime from 0 on a matching tick.
module machine_timer #(
  parameter int          PSC_W   = 16,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_MLO    = 3'd1;
  localparam logic [2:0] A_MHI    = 3'd2;
  localparam logic [2:0] A_CMPLO  = 3'd3;
  localparam logic [2:0] A_CMPHI  = 3'd4;

  logic [2:0]       sel;
  logic             wr, rd;
  logic             wr_ctrl, wr_mlo, wr_mhi, wr_cmp_lo, wr_cmp_hi, wr_cmp;
  logic             en, int_en, pending, reload;
  logic [PSC_W-1:0] div, psc_cnt;
  logic [63:0]      mtime, mtimecmp;
  logic [31:0]      hi_shadow;
  logic             tick, match;
  logic [31:0]      ctrl_rd;
  logic             unused_bits;

  assign sel         = addr_i[4:2];
  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], data_i[15:4]};
  assign wr          = req_i & we_i;
  assign rd          = req_i & ~we_i;
  assign wr_ctrl     = wr & (sel == A_CTRL);
  assign wr_mlo      = wr & (sel == A_MLO);
  assign wr_mhi      = wr & (sel == A_MHI);
  assign wr_cmp_lo   = wr & (sel == A_CMPLO);
  assign wr_cmp_hi   = wr & (sel == A_CMPHI);
  assign wr_cmp      = wr_cmp_lo | wr_cmp_hi;

  assign tick  = en & (psc_cnt == div);
  assign match = mtime >= mtimecmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en      <= 1'b0;
      int_en  <= 1'b0;
      div     <= '0;
      psc_cnt <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= data_i[0];
        int_en <= data_i[1];
        div    <= data_i[16 +: PSC_W];
      end
      if (wr_ctrl || !en || tick) psc_cnt <= '0;
      else                        psc_cnt <= psc_cnt + 1'b1;
    end
  end

`ifdef MTIMER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       reload <= 1'b0;
    else if (wr_ctrl) reload <= data_i[3];
  end
`else
  logic unused_reload_bit;
  assign unused_reload_bit = data_i[3];
  assign reload = 1'b0;
`endif

  // A bus write to either mtime half suppresses the tick for the whole counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
    end else if (wr_mlo) begin
      mtime[31:0] <= data_i;
    end else if (wr_mhi) begin
      mtime[63:32] <= data_i;
    end else if (tick) begin
      mtime <= (reload && match) ? 64'd0 : mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= CMP_RST;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= data_i;
      if (wr_cmp_hi) mtimecmp[63:32] <= data_i;
    end
  end

  // Set has priority over clear; a compare rewrite masks that cycle's match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (match && !wr_cmp) begin
      pending <= 1'b1;
    end else if ((wr_ctrl && data_i[2]) || wr_cmp) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       hi_shadow <= '0;
    else if (rd && (sel == A_MLO))    hi_shadow <= mtime[63:32];
  end

  assign int_sig_o = pending & int_en;

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[0]           = en;
    ctrl_rd[1]           = int_en;
    ctrl_rd[2]           = pending;
    ctrl_rd[3]           = reload;
    ctrl_rd[16 +: PSC_W] = div;
  end

  always_comb begin
    data_o = '0;
    case (sel)
      A_CTRL:  data_o = ctrl_rd;
      A_MLO:   data_o = mtime[31:0];
      A_MHI:   data_o = hi_shadow;
      A_CMPLO: data_o = mtimecmp[31:0];
      A_CMPHI: data_o = mtimecmp[63:32];
      default: data_o = '0;
    endcase
  end

endmodule
